// File: rtl/program_loader_if.sv
// Byte-stream input and memory-programming output bundle for program_loader.
interface program_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic [31:0] programAddress;
    logic [7:0]  programByte;
    logic        programWrEn;
    logic        startProgram;
    logic        cpu_reset;
    logic        busy;
    logic        error;

    modport slave (
        input  in_valid, in_byte,
        output in_ready, programAddress, programByte, programWrEn,
               startProgram, cpu_reset, busy, error
    );

    modport master (
        output in_valid, in_byte,
        input  in_ready, programAddress, programByte, programWrEn,
               startProgram, cpu_reset, busy, error
    );
endinterface

// File: rtl/program_loader.sv
// Loads a framed, checksummed program image into byte memory and then
// hands the memory to the CPU by raising startProgram and releasing cpu_reset.
module program_loader #(
    parameter int unsigned MEM_BYTES    = 1024,
    parameter logic [7:0]  MAGIC        = 8'hA5,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MEM_BYTES + 1);
    localparam int unsigned LEN_W = 16;
    localparam int unsigned RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK, S_RELEASE, S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_sum;
    logic [RC_W-1:0]    r_rel_cnt;
    logic [31:0]        r_addr;
    logic [7:0]         r_byte;
    logic               r_wr_en;
    logic               r_start;
    logic               r_cpu_reset;
    logic               r_busy;
    logic               r_error;

    logic               w_ready;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len_full;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_err_set;
    logic               w_err_clr;

    assign w_ready     = (r_state == S_IDLE)    || (r_state == S_LEN_HI) ||
                         (r_state == S_LEN_LO)  || (r_state == S_PAYLOAD) ||
                         (r_state == S_CHECK);
    assign w_accept    = bus.in_valid && w_ready;
    assign w_len_full  = {r_len[15:8], bus.in_byte};
    assign w_count_inc = r_count + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state plus error set/clear decisions for each accepted byte.
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && (bus.in_byte == MAGIC)) begin
                    w_state_nxt = S_LEN_HI;
                    w_err_clr   = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (w_accept) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_len_full > LEN_W'(MEM_BYTES)) begin
                        w_state_nxt = S_IDLE;
                        w_err_set   = 1'b1;
                    end else if (w_len_full == '0) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_accept && (LEN_W'(w_count_inc) == r_len)) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_accept) begin
                    if (bus.in_byte == r_sum) begin
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err_set   = 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                if (r_rel_cnt == RC_W'(RESET_CYCLES - 1)) w_state_nxt = S_RUN;
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs, the latter decoded from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len       <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_rel_cnt   <= '0;
            r_addr      <= '0;
            r_byte      <= '0;
            r_wr_en     <= 1'b0;
            r_start     <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_accept && (r_state == S_LEN_HI)) r_len[15:8] <= bus.in_byte;
            if (w_accept && (r_state == S_LEN_LO)) begin
                r_len[7:0] <= bus.in_byte;
                r_count    <= '0;
                r_sum      <= '0;
            end
            if (w_accept && (r_state == S_PAYLOAD)) begin
                r_addr  <= 32'(r_count);
                r_byte  <= bus.in_byte;
                r_wr_en <= 1'b1;
                r_sum   <= r_sum + bus.in_byte;
                r_count <= w_count_inc;
            end
            if (r_state == S_RELEASE) r_rel_cnt <= r_rel_cnt + RC_W'(1);
            else                      r_rel_cnt <= '0;
            if (w_err_set)      r_error <= 1'b1;
            else if (w_err_clr) r_error <= 1'b0;
            r_busy      <= (w_state_nxt == S_LEN_HI) || (w_state_nxt == S_LEN_LO) ||
                           (w_state_nxt == S_PAYLOAD) || (w_state_nxt == S_CHECK);
            r_start     <= (w_state_nxt == S_RELEASE) || (w_state_nxt == S_RUN);
            r_cpu_reset <= (w_state_nxt != S_RUN);
        end
    end

    assign bus.in_ready       = w_ready;
    assign bus.programAddress = r_addr;
    assign bus.programByte    = r_byte;
    assign bus.programWrEn    = r_wr_en;
    assign bus.startProgram   = r_start;
    assign bus.cpu_reset      = r_cpu_reset;
    assign bus.busy           = r_busy;
    assign bus.error          = r_error;
endmodule

// File: tb/tb_program_loader.sv
// Randomized frame-level bench for program_loader with a transaction model
// of the expected memory image and handover outcome.
module tb_program_loader;
    localparam int unsigned MEM_BYTES    = 1024;
    localparam int unsigned RESET_CYCLES = 4;
    localparam logic [7:0]  MAGIC        = 8'hA5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    program_loader_if bus();

    program_loader #(
        .MEM_BYTES(MEM_BYTES), .MAGIC(MAGIC), .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [MEM_BYTES];
    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte memory fed by the programming port.
    always @(posedge clk) begin
        if (!reset && bus.programWrEn) begin
            wr_addr_q.push_back(int'(bus.programAddress));
            wr_data_q.push_back(bus.programByte);
            if (bus.programAddress < 32'(MEM_BYTES)) mem[bus.programAddress[9:0]] <= bus.programByte;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int gap_of(input int max_gap);
        return int'($urandom_range(0, max_gap));
    endfunction

    // Entered and left at a falling edge; acc reports whether the byte was taken.
    task automatic send(input logic [7:0] b, input int gap, output bit acc);
        bus.in_valid = 1'b0;
        repeat (gap) begin
            bus.in_byte = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        acc = bus.in_ready;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/in_ready"},  32'(bus.in_ready), 32'd1);
        check({tag, "/cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        check({tag, "/start"},     32'(bus.startProgram), 32'd0);
        check({tag, "/wren"},      32'(bus.programWrEn), 32'd0);
        check({tag, "/addr"},      bus.programAddress, 32'd0);
        check({tag, "/byte"},      32'(bus.programByte), 32'd0);
        check({tag, "/busy"},      32'(bus.busy), 32'd0);
        check({tag, "/error"},     32'(bus.error), 32'd0);
    endtask

    // Asynchronous reset pulse asserted mid-cycle; outputs checked before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // chk_mode: -1 correct checksum, -2 random wrong checksum, 0..255 explicit byte.
    task automatic run_frame(input logic [7:0] pl[$], input int chk_mode,
                             input int max_gap, input string tag);
        int         len = pl.size();
        int         sum = 0;
        int         n_rej = 0;
        int         n_bad = 0;
        int         exp_wr;
        bit         acc;
        bit         oversize;
        bit         good;
        logic [7:0] chk;
        logic [7:0] true_sum;
        oversize = (len > int'(MEM_BYTES));
        foreach (pl[i]) sum += int'(pl[i]);
        true_sum = 8'(sum);
        if (chk_mode == -1)      chk = true_sum;
        else if (chk_mode == -2) chk = true_sum ^ 8'(1 + $urandom_range(0, 254));
        else                     chk = 8'(chk_mode);
        good = !oversize && (chk == true_sum);
        wr_addr_q.delete();
        wr_data_q.delete();

        send(MAGIC, gap_of(max_gap), acc);
        if (!acc) n_rej++;
        check({tag, "/magic_err_clr"}, 32'(bus.error), 32'd0);
        check({tag, "/magic_busy"},    32'(bus.busy), 32'd1);
        send(8'(len >> 8), gap_of(max_gap), acc);
        if (!acc) n_rej++;
        send(8'(len), gap_of(max_gap), acc);
        if (!acc) n_rej++;
        if (!oversize) begin
            foreach (pl[i]) begin
                send(pl[i], gap_of(max_gap), acc);
                if (!acc) n_rej++;
            end
            send(chk, gap_of(max_gap), acc);
            if (!acc) n_rej++;
        end
        check({tag, "/refused"}, 32'(n_rej), 32'd0);

        if (good) begin
            check({tag, "/start"},     32'(bus.startProgram), 32'd1);
            check({tag, "/busy"},      32'(bus.busy), 32'd0);
            check({tag, "/error"},     32'(bus.error), 32'd0);
            check({tag, "/in_ready"},  32'(bus.in_ready), 32'd0);
            check({tag, "/cpu_rst_hold"}, 32'(bus.cpu_reset), 32'd1);
            repeat (RESET_CYCLES - 1) @(negedge clk);
            check({tag, "/cpu_rst_last"}, 32'(bus.cpu_reset), 32'd1);
            @(negedge clk);
            check({tag, "/cpu_rst_fall"}, 32'(bus.cpu_reset), 32'd0);
            check({tag, "/start_run"},    32'(bus.startProgram), 32'd1);
        end else begin
            check({tag, "/error"},     32'(bus.error), 32'd1);
            check({tag, "/start"},     32'(bus.startProgram), 32'd0);
            check({tag, "/cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
            check({tag, "/busy"},      32'(bus.busy), 32'd0);
            check({tag, "/in_ready"},  32'(bus.in_ready), 32'd1);
        end

        exp_wr = oversize ? 0 : len;
        check({tag, "/n_writes"}, 32'(wr_addr_q.size()), 32'(exp_wr));
        for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] != i || wr_data_q[i] !== pl[i]) n_bad++;
            if (mem[i] !== pl[i]) n_bad++;
        end
        check({tag, "/write_contents"}, 32'(n_bad), 32'd0);
    endtask

    initial begin
        logic [7:0] pl[$];
        bit         acc;
        int         nw;
        int         mode;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        do_reset("por");

        // Write strobe latency and drop on an idle cycle.
        send(MAGIC, 0, acc);
        send(8'h00, 0, acc);
        send(8'h02, 0, acc);
        send(8'h11, 0, acc);
        check("lat0/wren", 32'(bus.programWrEn), 32'd1);
        check("lat0/addr", bus.programAddress, 32'd0);
        check("lat0/byte", 32'(bus.programByte), 32'h11);
        send(8'h22, 0, acc);
        check("lat1/wren", 32'(bus.programWrEn), 32'd1);
        check("lat1/addr", bus.programAddress, 32'd1);
        check("lat1/byte", 32'(bus.programByte), 32'h22);
        @(negedge clk);
        check("lat/gap_wren", 32'(bus.programWrEn), 32'd0);
        send(8'h33, 0, acc);
        check("lat/start", 32'(bus.startProgram), 32'd1);
        do_reset("r1");

        pl = '{8'h11, 8'h22, 8'h33};
        run_frame(pl, -1, 0, "good");

        // Stream after RUN is refused.
        nw = wr_addr_q.size();
        for (int i = 0; i < 5; i++) begin
            send(8'($urandom), 0, acc);
            check("run/refuse", 32'(acc), 32'd0);
        end
        check("run/no_writes", 32'(wr_addr_q.size()), 32'(nw));
        check("run/cpu_reset", 32'(bus.cpu_reset), 32'd0);
        do_reset("r2");

        pl = '{8'hFF};
        run_frame(pl, 8'h00, 0, "badchk");
        run_frame(pl, 8'hFF, 1, "retry");
        do_reset("r3");

        pl.delete();
        for (int i = 0; i < int'(MEM_BYTES) + 1; i++) pl.push_back(8'h00);
        run_frame(pl, -1, 0, "oversize");
        send(8'h33, 0, acc);
        check("oversize/idle_busy", 32'(bus.busy), 32'd0);
        check("oversize/err_sticky", 32'(bus.error), 32'd1);
        do_reset("r4");

        pl.delete();
        for (int i = 0; i < int'(MEM_BYTES); i++) pl.push_back(8'($urandom));
        run_frame(pl, -1, 0, "maxlen");
        do_reset("r5");

        send(8'h00, 0, acc);
        check("garbage0/busy", 32'(bus.busy), 32'd0);
        send(8'h5A, 0, acc);
        check("garbage1/busy", 32'(bus.busy), 32'd0);
        pl.delete();
        run_frame(pl, -1, 0, "zerolen");
        do_reset("r6");

        pl = '{8'h11, 8'h22, 8'h33};
        run_frame(pl, -1, 1, "gaps");
        do_reset("r7");

        for (int t = 0; t < 10; t++) begin
            pl.delete();
            for (int i = 0; i < int'($urandom_range(1, 48)); i++) pl.push_back(8'($urandom));
            mode = ($urandom_range(0, 3) == 0) ? -2 : -1;
            run_frame(pl, mode, int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
            do_reset($sformatf("rr%0d", t));
        end

        // Reset during payload leaves written bytes in memory.
        send(MAGIC, 0, acc);
        send(8'h00, 0, acc);
        send(8'h03, 0, acc);
        send(8'hAA, 0, acc);
        send(8'hBB, 0, acc);
        do_reset("mid");
        check("mid/mem0", 32'(mem[0]), 32'hAA);
        check("mid/mem1", 32'(mem[1]), 32'hBB);
        pl = '{8'h01, 8'h02, 8'h03};
        run_frame(pl, -1, 0, "after_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Front-end that drives the memory programming port (`programAddress`, `programByte`, `programWrEn`, `startProgram`) from a framed byte stream. It replaces bench-driven programming.

- Receives a header-framed, checksummed program image one byte at a time over a valid/ready input.
- Writes the image into byte memory starting at address 0.
- Holds the CPU in reset while loading. On a good checksum it raises `startProgram`, then releases the CPU reset.

## Interface

Parameters:
- MEM_BYTES, 1024, memory size in bytes; the largest legal image length.
- MAGIC, 8'hA5, frame start byte.
- RESET_CYCLES, 4, cycles `cpu_reset` stays high after `startProgram` rises; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset values below immediately.
- in_valid  in  1  `in_byte` is valid.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; transfer occurs on an edge with `in_valid && in_ready`.
- programAddress  out  32  memory write address.
- programByte  out  8  memory write data.
- programWrEn  out  1  one-cycle write strobe.
- startProgram  out  1  programming finished, CPU owns memory; sticky until reset.
- cpu_reset  out  1  drives the CPU `reset` input.
- busy  out  1  a frame is in progress (states LEN_HI through CHECK).
- error  out  1  last frame was rejected; sticky.

## Operation

Frame format: MAGIC, LEN[15:8], LEN[7:0], LEN payload bytes, CHK. CHK is the 8-bit sum, modulo 256, of the payload bytes.

States and transitions:
- IDLE: `in_ready`=1.
  - Accepted byte == MAGIC → LEN_HI, `error` cleared.
  - Any other accepted byte is discarded; no flag is raised.
- LEN_HI: accept one byte into len[15:8] → LEN_LO.
- LEN_LO: accept one byte into len[7:0]. Clear count and sum. Then:
  - len > MEM_BYTES → IDLE, `error`=1.
  - len == 0 → CHECK.
  - otherwise → PAYLOAD.
- PAYLOAD: for each accepted byte:
  - Register `programAddress` = count, `programByte` = byte, `programWrEn` = 1 for the next cycle only.
  - Update sum += byte (8-bit wrap) and count += 1.
  - When count reaches len → CHECK.
- CHECK: accept one byte.
  - Byte == sum → RELEASE.
  - Otherwise → IDLE with `error`=1. Memory contents are left as written.
- RELEASE: `startProgram`=1, `cpu_reset`=1, `in_ready`=0. Stay RESET_CYCLES cycles → RUN.
- RUN: `startProgram`=1, `cpu_reset`=0, `in_ready`=0. Terminal until `reset`.

Output rules:
- `in_ready` is a combinational decode of state: 1 in IDLE, LEN_HI, LEN_LO, PAYLOAD and CHECK; 0 otherwise.
- `cpu_reset` is 1 in every state except RUN.
- Count is 11 bits (enough for MEM_BYTES = 1024). Addresses are therefore always < MEM_BYTES; no wrap-around is possible.

## Timing

- Reset values:
  - state = IDLE, `in_ready`=1, `cpu_reset`=1.
  - `startProgram`=0, `programWrEn`=0, `programAddress`=0, `programByte`=0.
  - `busy`=0, `error`=0; count, sum and len are 0.
- Write latency: payload byte accepted at edge N → `programWrEn`=1 during cycle N..N+1 → memory written at edge N+1.
- One byte per cycle sustained; back-to-back `programWrEn` pulses are allowed.
- Gaps in `in_valid` stall the FSM with no state change. `programWrEn` drops to 0 during any cycle with no new payload accept.
- CHK accepted at edge C:
  - `startProgram`=1 and `busy`=0 from C.
  - `cpu_reset` falls at edge C+RESET_CYCLES.
  - The final payload write (edge C) precedes `startProgram`, so no write is lost.
- `reset` asserted in any state, including mid-payload: all outputs return to reset values asynchronously. The partial frame is abandoned; bytes already written stay in memory.

## Test plan

- Good frame: A5 00 03 11 22 33 66 →
  - `programWrEn` pulses at addresses 0/1/2 with data 11/22/33; memory holds 11 22 33.
  - `startProgram`=1 after the 66 byte; `cpu_reset` falls 4 cycles later; `error`=0.
- Bad checksum: A5 00 01 FF 00 → `error`=1, state IDLE, `startProgram`=0, `cpu_reset`=1. Then A5 00 01 FF FF → `error` clears on A5 and the load succeeds.
- Oversize: A5 04 01 → `error`=1 right after the 01 byte. No `programWrEn` pulses; next byte is treated in IDLE.
- Garbage and zero length: 00 5A A5 00 00 00 → first two bytes ignored. No `programWrEn` pulses; `startProgram`=1 after the final 00.
- Backpressure and gaps:
  - Good frame with `in_valid` toggling every other cycle → identical memory contents.
  - After RUN, `in_ready` stays 0 and further `in_valid` is ignored.
- Async reset mid-payload (after 2 of 3 payload bytes): all outputs take reset values before the next clock edge. Then a full good frame loads correctly.
